// File: rtl/enemy_pool_if.sv
// Enemy pool bus: game control inputs and per-slot object outputs.
//   start, pause    : game running / freeze request
//   rand_in         : fresh random value each frame
//   slot_valid/kind : per-slot occupancy and kind (0 = ground, 1 = air)
//   slot_x/y/w/h    : packed per-slot geometry, slot i at [i*W +: W]
//   speed           : current movement per frame
//   spawn_pulse     : one-cycle pulse on each spawn
// master drives the controls (game logic / bench); slave is the pool controller.
interface enemy_pool_if #(
   parameter int unsigned SLOTS = 4,
   parameter int unsigned XW    = 10,
   parameter int unsigned YW    = 9,
   parameter int unsigned SW    = 6,
   parameter int unsigned RANDW = 8
) ();
   logic                  start;
   logic                  pause;
   logic [RANDW-1:0]      rand_in;
   logic [SLOTS-1:0]      slot_valid;
   logic [SLOTS-1:0]      slot_kind;
   logic [SLOTS*XW-1:0]   slot_x;
   logic [SLOTS*YW-1:0]   slot_y;
   logic [SLOTS*SW-1:0]   slot_w;
   logic [SLOTS*SW-1:0]   slot_h;
   logic [XW-1:0]         speed;
   logic                  spawn_pulse;

   modport master (
      output start, pause, rand_in,
      input  slot_valid, slot_kind, slot_x, slot_y, slot_w, slot_h, speed, spawn_pulse
   );

   modport slave (
      input  start, pause, rand_in,
      output slot_valid, slot_kind, slot_x, slot_y, slot_w, slot_h, speed, spawn_pulse
   );
endinterface

// File: rtl/enemy_pool_ctrl.sv
// Enemy pool controller: manages SLOTS ground/air enemies per frame (clk3).
// Randomised minimum spawn gap, speed ramp every STEP_FRAMES running frames,
// slots retire instead of moving past the left edge.
//   clk3  : frame clock
//   reset : asynchronous active-low reset
//   bus   : enemy_pool_if slave (controls in, packed slot state out)
module enemy_pool_ctrl #(
   parameter int unsigned SLOTS         = 4,
   parameter int unsigned XW            = 10,
   parameter int unsigned YW            = 9,
   parameter int unsigned SW            = 6,
   parameter int unsigned RANDW         = 8,
   parameter int unsigned SCREEN_W      = 640,
   parameter int unsigned GROUND_Y      = 400,
   parameter int unsigned AIR_Y         = 340,
   parameter int unsigned GROUND_W      = 20,
   parameter int unsigned GROUND_H      = 40,
   parameter int unsigned AIR_W         = 40,
   parameter int unsigned AIR_H         = 24,
   parameter int unsigned MIN_GAP       = 32,
   parameter int unsigned SPEED_INIT    = 4,
   parameter int unsigned SPEED_MAX     = 12,
   parameter int unsigned STEP_FRAMES   = 256,
   parameter int unsigned AIR_MIN_SPEED = 6
) (
   input logic          clk3,
   input logic          reset,
   enemy_pool_if.slave  bus
);

   localparam int unsigned CW = $clog2(MIN_GAP + 16) + 1;
   localparam int unsigned FW = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
   localparam int unsigned IW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

   typedef enum logic [1:0] {StIdle, StRun, StHold} state_e;

   state_e            state_q;
   logic [SLOTS-1:0]  valid_q;
   logic [SLOTS-1:0]  kind_q;
   logic [XW-1:0]     x_q [SLOTS];
   logic [YW-1:0]     y_q [SLOTS];
   logic [SW-1:0]     w_q [SLOTS];
   logic [SW-1:0]     h_q [SLOTS];
   logic [XW-1:0]     speed_q;
   logic [CW-1:0]     cool_q;
   logic [FW-1:0]     frame_q;
   logic              pulse_q;

   logic              free_found;
   logic [IW-1:0]     free_idx;
   logic              spawn_go;
   logic              spawn_air;
   logic              run_go;
   logic              unused_rand;

   assign unused_rand = ^bus.rand_in;

   // Lowest free slot, judged on registered valid so a slot retiring this
   // edge is only reusable from the next edge.
   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      for (int i = 0; i < int'(SLOTS); i++) begin
         if (!valid_q[i] && !free_found) begin
            free_found = 1'b1;
            free_idx   = IW'(i);
         end
      end
   end

   assign run_go    = (state_q == StRun) && bus.start && !bus.pause;
   assign spawn_go  = run_go && (cool_q == '0) && (bus.rand_in[RANDW-1 -: 2] == 2'b00) &&
                      free_found;
   assign spawn_air = bus.rand_in[4] && (speed_q >= XW'(AIR_MIN_SPEED));

   always_ff @(posedge clk3 or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         valid_q <= '0;
         kind_q  <= '0;
         for (int i = 0; i < int'(SLOTS); i++) begin
            x_q[i] <= '0;
            y_q[i] <= '0;
            w_q[i] <= '0;
            h_q[i] <= '0;
         end
         speed_q <= XW'(SPEED_INIT);
         cool_q  <= '0;
         frame_q <= '0;
         pulse_q <= 1'b0;
      end else if (!bus.start) begin
         // Geometry of retired slots is left as-is; only occupancy clears.
         state_q <= StIdle;
         valid_q <= '0;
         speed_q <= XW'(SPEED_INIT);
         cool_q  <= '0;
         frame_q <= '0;
         pulse_q <= 1'b0;
      end else begin
         case (state_q)
            StIdle, StHold: begin
               pulse_q <= 1'b0;
               if (!bus.pause) state_q <= StRun;
            end
            StRun: begin
               if (bus.pause) begin
                  state_q <= StHold;
                  pulse_q <= 1'b0;
               end else begin
                  for (int i = 0; i < int'(SLOTS); i++) begin
                     if (valid_q[i]) begin
                        if (x_q[i] < speed_q) valid_q[i] <= 1'b0;
                        else                  x_q[i]     <= x_q[i] - speed_q;
                     end
                  end
                  // Spawn target is a free slot, so the move loop never touches it.
                  if (spawn_go) begin
                     valid_q[free_idx] <= 1'b1;
                     kind_q[free_idx]  <= spawn_air;
                     x_q[free_idx]     <= XW'(SCREEN_W);
                     y_q[free_idx]     <= spawn_air ? YW'(AIR_Y) : YW'(GROUND_Y);
                     w_q[free_idx]     <= spawn_air ? SW'(AIR_W) : SW'(GROUND_W);
                     h_q[free_idx]     <= spawn_air ? SW'(AIR_H) : SW'(GROUND_H);
                     cool_q            <= CW'(MIN_GAP) + CW'(bus.rand_in[3:0]);
                  end else if (cool_q != '0) begin
                     cool_q <= cool_q - CW'(1);
                  end
                  if (frame_q == FW'(STEP_FRAMES - 1)) begin
                     frame_q <= '0;
                     if (speed_q < XW'(SPEED_MAX)) speed_q <= speed_q + XW'(1);
                  end else begin
                     frame_q <= frame_q + FW'(1);
                  end
                  pulse_q <= spawn_go;
               end
            end
            default: begin
               state_q <= StIdle;
               pulse_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.slot_valid  = valid_q;
   assign bus.slot_kind   = kind_q;
   assign bus.speed       = speed_q;
   assign bus.spawn_pulse = pulse_q;

   for (genvar g = 0; g < int'(SLOTS); g++) begin : g_pack
      assign bus.slot_x[g*XW +: XW] = x_q[g];
      assign bus.slot_y[g*YW +: YW] = y_q[g];
      assign bus.slot_w[g*SW +: SW] = w_q[g];
      assign bus.slot_h[g*SW +: SW] = h_q[g];
   end

endmodule

// File: tb/tb_enemy_pool_ctrl.sv
// Testbench for enemy_pool_ctrl: directed scenarios with literal expectations,
// then randomized control/random-input traffic, all checked every frame
// against a behavioural pool model.
module tb_enemy_pool_ctrl;
   localparam int SLOTS = 4;
   localparam int XW    = 10;
   localparam int YW    = 9;
   localparam int SW    = 6;
   localparam int RANDW = 8;

   localparam int MIdle = 0;
   localparam int MRun  = 1;
   localparam int MHold = 2;

   logic clk3  = 1'b0;
   logic reset = 1'b0;
   always #5 clk3 = ~clk3;

   enemy_pool_if #(.SLOTS(SLOTS), .XW(XW), .YW(YW), .SW(SW), .RANDW(RANDW)) bus ();

   enemy_pool_ctrl #(.SLOTS(SLOTS), .XW(XW), .YW(YW), .SW(SW), .RANDW(RANDW)) dut (
      .clk3  (clk3),
      .reset (reset),
      .bus   (bus)
   );

   int tests = 0;
   int fails = 0;

   // Behavioural model of the pool.
   int m_mode;
   bit m_valid [SLOTS];
   bit m_kind  [SLOTS];
   int m_x [SLOTS];
   int m_y [SLOTS];
   int m_w [SLOTS];
   int m_h [SLOTS];
   int m_speed, m_cool, m_cnt;
   bit m_pulse;

   function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic void model_reset();
      m_mode = MIdle;
      for (int i = 0; i < SLOTS; i++) begin
         m_valid[i] = 0; m_kind[i] = 0;
         m_x[i] = 0; m_y[i] = 0; m_w[i] = 0; m_h[i] = 0;
      end
      m_speed = 4; m_cool = 0; m_cnt = 0; m_pulse = 0;
   endfunction

   function automatic void model_step();
      int  r;
      int  free;
      bit  spawn;
      bit  air;
      bit  old_valid [SLOTS];
      r = int'(bus.rand_in);
      if (!bus.start) begin
         m_mode = MIdle;
         for (int i = 0; i < SLOTS; i++) m_valid[i] = 0;
         m_speed = 4; m_cool = 0; m_cnt = 0; m_pulse = 0;
      end else if (m_mode != MRun) begin
         m_pulse = 0;
         if (!bus.pause) m_mode = MRun;
      end else if (bus.pause) begin
         m_mode  = MHold;
         m_pulse = 0;
      end else begin
         old_valid = m_valid;
         free = -1;
         for (int i = SLOTS - 1; i >= 0; i--) if (!old_valid[i]) free = i;
         spawn = (m_cool == 0) && (((r >> (RANDW - 2)) & 3) == 0) && (free >= 0);
         air   = (((r >> 4) & 1) == 1) && (m_speed >= 6);
         for (int i = 0; i < SLOTS; i++) begin
            if (old_valid[i]) begin
               if (m_x[i] < m_speed) m_valid[i] = 0;
               else                  m_x[i] = m_x[i] - m_speed;
            end
         end
         if (spawn) begin
            m_valid[free] = 1;
            m_kind[free]  = air;
            m_x[free]     = 640;
            m_y[free]     = air ? 340 : 400;
            m_w[free]     = air ? 40 : 20;
            m_h[free]     = air ? 24 : 40;
            m_cool        = 32 + (r & 15);
         end else if (m_cool > 0) begin
            m_cool = m_cool - 1;
         end
         if (m_cnt == 255) begin
            m_cnt = 0;
            if (m_speed < 12) m_speed = m_speed + 1;
         end else begin
            m_cnt = m_cnt + 1;
         end
         m_pulse = spawn;
      end
   endfunction

   task automatic compare();
      logic [SLOTS-1:0]    ev, ek;
      logic [SLOTS*XW-1:0] ex;
      logic [SLOTS*YW-1:0] ey;
      logic [SLOTS*SW-1:0] ew, eh;
      for (int i = 0; i < SLOTS; i++) begin
         ev[i] = m_valid[i];
         ek[i] = m_kind[i];
         ex[i*XW +: XW] = m_x[i][XW-1:0];
         ey[i*YW +: YW] = m_y[i][YW-1:0];
         ew[i*SW +: SW] = m_w[i][SW-1:0];
         eh[i*SW +: SW] = m_h[i][SW-1:0];
      end
      check("slot_valid", 64'(bus.slot_valid), 64'(ev));
      check("slot_kind", 64'(bus.slot_kind), 64'(ek));
      check("slot_x", 64'(bus.slot_x), 64'(ex));
      check("slot_y", 64'(bus.slot_y), 64'(ey));
      check("slot_w", 64'(bus.slot_w), 64'(ew));
      check("slot_h", 64'(bus.slot_h), 64'(eh));
      check("speed", 64'(bus.speed), 64'(m_speed));
      check("spawn_pulse", 64'(bus.spawn_pulse), 64'(m_pulse));
   endtask

   // One frame: model follows the edge, outputs checked on the falling edge.
   task automatic cycle();
      @(posedge clk3);
      model_step();
      @(negedge clk3);
      compare();
   endtask

   task automatic wait_pulse(input int start_n, input int limit, output int n);
      n = start_n;
      do begin
         cycle();
         n++;
      end while (!bus.spawn_pulse && n < limit);
   endtask

   task automatic async_reset();
      #2 reset = 1'b0;
      model_reset();
      #1 compare();
      @(negedge clk3);
      compare();
      reset = 1'b1;
   endtask

   int n;

   initial begin
      bus.start   = 1'b0;
      bus.pause   = 1'b0;
      bus.rand_in = '0;
      model_reset();
      #12;
      compare();
      check("rst_valid", 64'(bus.slot_valid), 64'(0));
      check("rst_speed", 64'(bus.speed), 64'(4));
      @(negedge clk3);
      reset = 1'b1;

      // First spawn and move.
      bus.start = 1'b1; bus.rand_in = 8'h05;
      cycle();
      check("run_entry_valid", 64'(bus.slot_valid), 64'(0));
      cycle();
      check("sp_pulse", 64'(bus.spawn_pulse), 64'(1));
      check("sp_valid", 64'(bus.slot_valid), 64'(4'b0001));
      check("sp_x0", 64'(bus.slot_x[0 +: XW]), 64'(640));
      check("sp_kind0", 64'(bus.slot_kind[0]), 64'(0));
      check("sp_y0", 64'(bus.slot_y[0 +: YW]), 64'(400));
      check("sp_w0", 64'(bus.slot_w[0 +: SW]), 64'(20));
      check("sp_h0", 64'(bus.slot_h[0 +: SW]), 64'(40));
      bus.rand_in = 8'h00;
      cycle();
      check("mv_x0", 64'(bus.slot_x[0 +: XW]), 64'(636));
      check("mv_pulse", 64'(bus.spawn_pulse), 64'(0));
      // Cooldown 37 means the next spawn lands 38 frames after the first.
      wait_pulse(1, 100, n);
      check("gap_frames", 64'(n), 64'(38));
      check("gap_valid", 64'(bus.slot_valid), 64'(4'b0011));
      check("gap_x0", 64'(bus.slot_x[0 +: XW]), 64'(488));
      check("gap_x1", 64'(bus.slot_x[XW +: XW]), 64'(640));

      // Left-edge exit of slot0.
      bus.rand_in = 8'hC0;
      repeat (122) cycle();
      check("edge_x0_zero", 64'(bus.slot_x[0 +: XW]), 64'(0));
      check("edge_v0_kept", 64'(bus.slot_valid[0]), 64'(1));
      cycle();
      check("edge_v0_freed", 64'(bus.slot_valid[0]), 64'(0));
      check("edge_x0_hold", 64'(bus.slot_x[0 +: XW]), 64'(0));

      // Air request at low speed stays ground.
      bus.rand_in = 8'h10;
      cycle();
      check("gate_pulse", 64'(bus.spawn_pulse), 64'(1));
      check("gate_kind0", 64'(bus.slot_kind[0]), 64'(0));
      check("gate_y0", 64'(bus.slot_y[0 +: YW]), 64'(400));
      bus.rand_in = 8'h00;
      wait_pulse(0, 100, n);
      check("gap32_frames", 64'(n), 64'(33));
      check("three_valid", 64'(bus.slot_valid), 64'(4'b0111));

      // Asynchronous reset with three slots live.
      bus.rand_in = 8'hC0;
      #2 reset = 1'b0;
      model_reset();
      #1;
      check("areset_valid", 64'(bus.slot_valid), 64'(0));
      check("areset_speed", 64'(bus.speed), 64'(4));
      check("areset_pulse", 64'(bus.spawn_pulse), 64'(0));
      compare();
      @(negedge clk3);
      reset = 1'b1;

      // Speed ramp with a HOLD window in the middle.
      cycle();
      repeat (128) cycle();
      bus.pause = 1'b1;
      repeat (50) cycle();
      bus.pause = 1'b0;
      cycle();
      repeat (127) cycle();
      check("ramp_before", 64'(bus.speed), 64'(4));
      cycle();
      check("ramp_after", 64'(bus.speed), 64'(5));
      repeat (2560 - 256) cycle();
      check("ramp_sat", 64'(bus.speed), 64'(12));

      // Air spawn once fast enough, then drop start.
      bus.rand_in = 8'h10;
      cycle();
      check("air_pulse", 64'(bus.spawn_pulse), 64'(1));
      check("air_kind0", 64'(bus.slot_kind[0]), 64'(1));
      check("air_y0", 64'(bus.slot_y[0 +: YW]), 64'(340));
      check("air_w0", 64'(bus.slot_w[0 +: SW]), 64'(40));
      check("air_h0", 64'(bus.slot_h[0 +: SW]), 64'(24));
      bus.start = 1'b0;
      cycle();
      check("idle_valid", 64'(bus.slot_valid), 64'(0));
      check("idle_speed", 64'(bus.speed), 64'(4));

      // Randomized traffic.
      bus.start = 1'b1;
      for (int i = 0; i < 6000; i++) begin
         if ($urandom_range(0, 999) == 0) async_reset();
         if (bus.start) begin
            if ($urandom_range(0, 999) == 0) bus.start = 1'b0;
         end else if ($urandom_range(0, 4) == 0) begin
            bus.start = 1'b1;
         end
         if ($urandom_range(0, 29) == 0) bus.pause = ~bus.pause;
         bus.rand_in = RANDW'($urandom);
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/enemy_pool_ctrl.md
Name: enemy_pool_ctrl

Overview:
Parametrised successor to the single-type enemy mover. It manages a pool of SLOTS enemy objects with two kinds, ground and air, driven by a per-frame clock (clk3). It applies a randomised minimum spawn gap and a speed level that ramps over time. Outputs feed the renderer and collision logic as packed per-slot vectors; slots never underflow past the left screen edge.

Parameters:
SLOTS, 4, number of enemy slots
XW, 10, x coordinate width
YW, 9, y coordinate width
SW, 6, width/height field width
RANDW, 8, random input width (must be >= 6)
SCREEN_W, 640, spawn x position
GROUND_Y, 400, y of ground enemy
AIR_Y, 340, y of air enemy
GROUND_W, 20 / GROUND_H, 40, ground enemy size
AIR_W, 40 / AIR_H, 24, air enemy size
MIN_GAP, 32, minimum frames between spawns
SPEED_INIT, 4, initial pixels per frame
SPEED_MAX, 12, speed saturation value
STEP_FRAMES, 256, RUN frames per speed increment
AIR_MIN_SPEED, 6, speed at which air enemies become eligible

Ports:
clk3  in  1  frame clock
reset  in  1  asynchronous active-low reset
start  in  1  game running
pause  in  1  freeze request
rand_in  in  RANDW  fresh random value each frame
slot_valid  out  SLOTS  slot occupied
slot_kind  out  SLOTS  per-slot kind, 0 = ground, 1 = air
slot_x  out  SLOTS*XW  packed x, slot i at [i*XW +: XW]
slot_y  out  SLOTS*YW  packed y
slot_w  out  SLOTS*SW  packed width
slot_h  out  SLOTS*SW  packed height
speed  out  XW  current movement per frame
spawn_pulse  out  1  high for one cycle when a spawn occurs

Behaviour:
- Reset (async, reset=0): all slot_valid=0, all slot fields=0, speed=SPEED_INIT, cooldown=0, frame counter=0, spawn_pulse=0, state=IDLE.
- States:
  - IDLE: start=0. All slots invalid, speed=SPEED_INIT, counters 0.
  - RUN: start=1, pause=0.
  - HOLD: start=1, pause=1. All registers frozen; spawn_pulse=0.
- Transitions, evaluated every posedge:
  - start=0 goes to IDLE from any state, clearing on that edge.
  - In IDLE with start=1, pause=0: go to RUN. The first movement happens on the following edge.
  - RUN with pause=1 goes to HOLD. HOLD with pause=0 goes to RUN.
- Movement (RUN, per valid slot, using registered values):
  - If x < speed: valid goes to 0 and x holds. There is no wrap or underflow.
  - Otherwise x decreases by speed.
  - y, w, h and kind hold.
- Spawn (RUN) occurs when cooldown==0 and rand_in[RANDW-1:RANDW-2]==0.
  - Target is the lowest-index slot with registered valid=0. A slot freed on this edge is not reusable until the next edge.
  - New slot: valid=1, x=SCREEN_W. It is not moved on the spawn edge.
  - Kind: air if rand_in[4]=1 and speed>=AIR_MIN_SPEED, else ground. y, w, h are taken from that kind's parameters.
  - Cooldown loads MIN_GAP + rand_in[3:0]. spawn_pulse=1 for that cycle only.
  - At most one spawn per frame.
  - If no slot is free, there is no spawn: cooldown stays 0 and spawn_pulse=0.
- Cooldown (RUN, no spawn): decrements when >0, saturates at 0.
- Speed ramp (RUN):
  - Frame counter counts 0..STEP_FRAMES-1. On wrap, speed increments by 1, saturating at SPEED_MAX.
  - Counter and speed freeze in HOLD.
  - A new speed applies to movement from the next edge.
- Output fields of invalid slots hold their last values; consumers must gate them with slot_valid.

Test Plan:
1. Reset is asserted mid-RUN with 3 slots valid → all slot_valid=0, speed=4 and spawn_pulse=0 immediately, without waiting for a clock edge.
2. Spawn and move: start=1, rand_in=8'h05 → slot0 valid, x=640, ground, y=400, w=20, h=40, cooldown=37. Next edge with rand_in=0 → x=636 and no spawn.
3. Slot exhaustion: force spawns every time cooldown hits 0 with 4 slots full → no 5th spawn, spawn_pulse stays 0, cooldown holds 0. When slot0 exits, spawn occurs on the following edge into slot0.
4. Edge exit: slot at x=3 with speed=4 → valid=0 and x stays 3. Slot at x=4 → x=0, still valid, freed on the next edge.
5. Speed ramp: 256 RUN frames → speed=5. With 128 RUN, 50 HOLD, 128 RUN frames → speed=5 only after the last RUN frame. After 2560 frames → speed saturates at 12.
6. Air gating: rand_in=8'h10 with speed=4 → ground spawn. After speed reaches 6, rand_in=8'h10 → air, y=340, w=40, h=24. start dropped → IDLE clears all slots and speed=4.
